// File: rtl/memory_bus_controller.sv
// memory_bus_controller: bridges memory-stage load/store requests to a 32-bit big-endian acked bus.
// Define BUS_TIMEOUT_EN to abort an ACCESS with bus_error after TIMEOUT_CYCLES clocks without bus_ack.
module memory_bus_controller #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        memory_access_cycle,
   input  logic        memory_read,
   input  logic        memory_write,
   input  logic [1:0]  memory_cycle_width,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic        busy,
   output logic        done,
   output logic        bus_error,
   output logic [31:0] read_data,
   output logic [29:0] bus_address,
   output logic [31:0] bus_data_out,
   input  logic [31:0] bus_data_in,
   output logic [3:0]  bus_data_strobes,
   output logic        bus_read,
   output logic        bus_write,
   input  logic        bus_ack
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} state_t;
   state_t      state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [1:0]  off_q, off_d, width_q, width_d;
   logic        rd_q, rd_d, bus_read_q, bus_read_d, bus_write_q, bus_write_d;
   logic [3:0]  strb_q, strb_d;
   logic [31:0] dout_q, dout_d, rdata_q, rdata_d;
   logic        bad_req;
   logic [3:0]  strb_req;
   logic [31:0] wdata_req, load_data;
   logic [15:0] word_sel;
   logic [7:0]  byte_sel;
`ifdef BUS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   assign bad_req = (memory_cycle_width == 2'b11) || (memory_read == memory_write) ||
                    (memory_cycle_width == 2'b01 && address[0]) ||
                    (memory_cycle_width == 2'b00 && address[1:0] != 2'b00);
   assign strb_req  = memory_cycle_width == 2'b00 ? 4'b1111 :
                      memory_cycle_width == 2'b01 ? (address[1] ? 4'b0011 : 4'b1100) :
                      4'b1000 >> address[1:0];
   assign wdata_req = memory_cycle_width == 2'b00 ? write_data :
                      memory_cycle_width == 2'b01 ? {2{write_data[15:0]}} : {4{write_data[7:0]}};
   // Lane 0 is the most significant byte, so low offsets select the high bits.
   assign word_sel  = off_q[1] ? bus_data_in[15:0] : bus_data_in[31:16];
   assign byte_sel  = off_q[0] ? word_sel[7:0] : word_sel[15:8];
   assign load_data = width_q == 2'b00 ? bus_data_in :
                      width_q == 2'b01 ? {16'h0, word_sel} : {24'h0, byte_sel};

   assign busy             = state_q != IDLE;
   assign done             = state_q == DONE || state_q == ERROR;
   assign bus_error        = state_q == ERROR;
   assign read_data        = rdata_q;
   assign bus_address      = addr_q;
   assign bus_data_out     = dout_q;
   assign bus_data_strobes = strb_q;
   assign bus_read         = bus_read_q;
   assign bus_write        = bus_write_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      off_d       = off_q;
      width_d     = width_q;
      rd_d        = rd_q;
      dout_d      = dout_q;
      rdata_d     = rdata_q;
      strb_d      = strb_q;
      bus_read_d  = bus_read_q;
      bus_write_d = bus_write_q;
`ifdef BUS_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (memory_access_cycle && bad_req) state_d = ERROR;
            else if (memory_access_cycle) begin
               state_d     = ACCESS;
               addr_d      = address[31:2];
               off_d       = address[1:0];
               width_d     = memory_cycle_width;
               rd_d        = memory_read;
               dout_d      = wdata_req;
               strb_d      = strb_req;
               bus_read_d  = memory_read;
               bus_write_d = memory_write;
`ifdef BUS_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         ACCESS: begin
            if (bus_ack) begin
               state_d     = DONE;
               rdata_d     = rd_q ? load_data : rdata_q;
               strb_d      = 4'b0000;
               bus_read_d  = 1'b0;
               bus_write_d = 1'b0;
            end
`ifdef BUS_TIMEOUT_EN
            else if (cnt_q == CNT_MAX) begin
               state_d     = ERROR;
               strb_d      = 4'b0000;
               bus_read_d  = 1'b0;
               bus_write_d = 1'b0;
            end
            else cnt_d = cnt_q + 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         off_q       <= '0;
         width_q     <= '0;
         rd_q        <= 1'b0;
         dout_q      <= '0;
         rdata_q     <= '0;
         strb_q      <= '0;
         bus_read_q  <= 1'b0;
         bus_write_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         off_q       <= off_d;
         width_q     <= width_d;
         rd_q        <= rd_d;
         dout_q      <= dout_d;
         rdata_q     <= rdata_d;
         strb_q      <= strb_d;
         bus_read_q  <= bus_read_d;
         bus_write_q <= bus_write_d;
`ifdef BUS_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_memory_bus_controller.sv
// tb_memory_bus_controller: directed checks of the memory bus controller, with or without BUS_TIMEOUT_EN.
module tb_memory_bus_controller;
   logic        clock = 0, reset = 1, mac = 0, mrd = 0, mwr = 0, bus_ack = 0;
   logic [1:0]  mw = 0;
   logic [31:0] address = 0, write_data = 0, bus_data_in = 0;
   logic        busy, done, bus_error, bus_read, bus_write;
   logic [31:0] read_data, bus_data_out;
   logic [29:0] bus_address;
   logic [3:0]  bus_data_strobes;
   int n_chk = 0, n_fail = 0;

   // {busy, done, bus_error, bus_read, bus_write, strobes}
   wire [8:0] st = {busy, done, bus_error, bus_read, bus_write, bus_data_strobes};
   localparam logic [8:0] S_IDLE = 9'b0_0_0_0_0_0000;
   localparam logic [8:0] S_DONE = 9'b1_1_0_0_0_0000;
   localparam logic [8:0] S_ERR  = 9'b1_1_1_0_0_0000;

   memory_bus_controller #(.TIMEOUT_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .memory_access_cycle(mac), .memory_read(mrd),
      .memory_write(mwr), .memory_cycle_width(mw), .address(address), .write_data(write_data),
      .busy(busy), .done(done), .bus_error(bus_error), .read_data(read_data),
      .bus_address(bus_address), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
      .bus_data_strobes(bus_data_strobes), .bus_read(bus_read), .bus_write(bus_write),
      .bus_ack(bus_ack)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start(input logic rd, input logic wr, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] wd);
      mac = 1; mrd = rd; mwr = wr; mw = w; address = a; write_data = wd;
      tick();
      mac = 0;
   endtask

   task automatic test_reset();
      #3;
      if (st !== S_IDLE) begin n_fail++; $display("FAIL reset_status: got %b expected %b", st, S_IDLE); end
      n_chk++;
      if ({read_data, bus_address, bus_data_out} !== 94'h0) begin
         n_fail++; $display("FAIL reset_regs: got %h/%h/%h expected 0", read_data, bus_address, bus_data_out);
      end
      n_chk++;
      tick();
      reset = 0;
      tick();
      if (st !== S_IDLE) begin n_fail++; $display("FAIL idle_after_reset: got %b expected %b", st, S_IDLE); end
      n_chk++;
   endtask

   task automatic test_long_read();
      start(1, 0, 2'b00, 32'h100, 0);
      if (st !== 9'b1_0_0_1_0_1111) begin n_fail++; $display("FAIL long_read_access: got %b expected 100101111", st); end
      n_chk++;
      if (bus_address !== 30'h40) begin n_fail++; $display("FAIL long_read_addr: got %h expected 40", bus_address); end
      n_chk++;
      tick();
      tick();
      if (st !== 9'b1_0_0_1_0_1111) begin n_fail++; $display("FAIL long_read_wait: got %b expected 100101111", st); end
      n_chk++;
      bus_ack = 1; bus_data_in = 32'hDEADBEEF;
      tick();
      bus_ack = 0;
      if (st !== S_DONE) begin n_fail++; $display("FAIL long_read_done: got %b expected %b", st, S_DONE); end
      n_chk++;
      if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL long_read_data: got %h expected deadbeef", read_data); end
      n_chk++;
      tick();
      if (st !== S_IDLE) begin n_fail++; $display("FAIL long_read_idle: got %b expected %b", st, S_IDLE); end
      n_chk++;
   endtask

   task automatic test_byte_write();
      start(0, 1, 2'b10, 32'h203, 32'h000000A5);
      if (st !== 9'b1_0_0_0_1_0001) begin n_fail++; $display("FAIL byte_write_access: got %b expected 100010001", st); end
      n_chk++;
      if (bus_data_out !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL byte_write_data: got %h expected a5a5a5a5", bus_data_out); end
      n_chk++;
      bus_ack = 1;
      tick();
      bus_ack = 0;
      if (st !== S_DONE) begin n_fail++; $display("FAIL byte_write_done: got %b expected %b", st, S_DONE); end
      n_chk++;
      if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byte_write_rdata: got %h expected deadbeef", read_data); end
      n_chk++;
      tick();
   endtask

   task automatic test_word_read();
      bus_ack = 1; bus_data_in = 32'h1234ABCD;
      start(1, 0, 2'b01, 32'h100, 0);
      if (st !== 9'b1_0_0_1_0_1100) begin n_fail++; $display("FAIL word0_access: got %b expected 100101100", st); end
      n_chk++;
      tick();
      if (read_data !== 32'h00001234) begin n_fail++; $display("FAIL word0_data: got %h expected 00001234", read_data); end
      n_chk++;
      tick();
      start(1, 0, 2'b01, 32'h102, 0);
      if (st !== 9'b1_0_0_1_0_0011) begin n_fail++; $display("FAIL word2_access: got %b expected 100100011", st); end
      n_chk++;
      tick();
      if ({st, read_data} !== {S_DONE, 32'h0000ABCD}) begin
         n_fail++; $display("FAIL word2_done: got %b %h expected %b 0000abcd", st, read_data, S_DONE);
      end
      n_chk++;
      bus_ack = 0;
      tick();
   endtask

   task automatic test_misaligned();
      logic [35:0] bad [5] = '{{1'b0, 1'b1, 2'b01, 32'h101}, {1'b1, 1'b0, 2'b00, 32'h102},
                               {1'b1, 1'b0, 2'b11, 32'h0},   {1'b1, 1'b1, 2'b00, 32'h0},
                               {1'b0, 1'b0, 2'b00, 32'h0}};
      for (int i = 0; i < 5; i++) begin
         bus_ack = 1;
         start(bad[i][35], bad[i][34], bad[i][33:32], bad[i][31:0], 32'hFFFFFFFF);
         if (st !== S_ERR) begin n_fail++; $display("FAIL bad_req%0d_err: got %b expected %b", i, st, S_ERR); end
         n_chk++;
         tick();
         bus_ack = 0;
         if ({st, read_data} !== {S_IDLE, 32'h0000ABCD}) begin
            n_fail++; $display("FAIL bad_req%0d_idle: got %b %h expected %b 0000abcd", i, st, read_data, S_IDLE);
         end
         n_chk++;
      end
   endtask

   task automatic test_back_to_back();
      bus_ack = 1; bus_data_in = 32'h11223344;
      start(1, 0, 2'b10, 32'h401, 0);
      if (st !== 9'b1_0_0_1_0_0100) begin n_fail++; $display("FAIL b2b_a_access: got %b expected 100100100", st); end
      n_chk++;
      mac = 1; mrd = 1; mw = 2'b00; address = 32'h800;
      tick();
      if ({st, read_data} !== {S_DONE, 32'h00000022}) begin
         n_fail++; $display("FAIL b2b_a_done: got %b %h expected %b 00000022", st, read_data, S_DONE);
      end
      n_chk++;
      address = 32'h500; bus_data_in = 32'hCAFEF00D;
      tick();
      if ({st, bus_address} !== {S_IDLE, 30'h100}) begin
         n_fail++; $display("FAIL b2b_busy_ignored: got %b %h expected %b 100", st, bus_address, S_IDLE);
      end
      n_chk++;
      tick();
      mac = 0;
      if ({st, bus_address} !== {9'b1_0_0_1_0_1111, 30'h140}) begin
         n_fail++; $display("FAIL b2b_b_access: got %b %h expected 100101111 140", st, bus_address);
      end
      n_chk++;
      tick();
      bus_ack = 0;
      if ({st, read_data} !== {S_DONE, 32'hCAFEF00D}) begin
         n_fail++; $display("FAIL b2b_b_done: got %b %h expected %b cafef00d", st, read_data, S_DONE);
      end
      n_chk++;
      tick();
   endtask

   task automatic test_timeout();
      bus_ack = 0;
      start(1, 0, 2'b00, 32'h600, 0);
`ifdef BUS_TIMEOUT_EN
      repeat (3) tick();
      if (st !== 9'b1_0_0_1_0_1111) begin n_fail++; $display("FAIL timeout_wait: got %b expected 100101111", st); end
      n_chk++;
      tick();
      if (st !== S_ERR) begin n_fail++; $display("FAIL timeout_err: got %b expected %b", st, S_ERR); end
      n_chk++;
      tick();
      if (st !== S_IDLE) begin n_fail++; $display("FAIL timeout_idle: got %b expected %b", st, S_IDLE); end
      n_chk++;
`else
      repeat (20) tick();
      if (st !== 9'b1_0_0_1_0_1111) begin n_fail++; $display("FAIL no_timeout_wait: got %b expected 100101111", st); end
      n_chk++;
      bus_ack = 1;
      tick();
      bus_ack = 0;
      if (st !== S_DONE) begin n_fail++; $display("FAIL no_timeout_done: got %b expected %b", st, S_DONE); end
      n_chk++;
      tick();
`endif
   endtask

   task automatic test_reset_mid_access();
      bus_ack = 0;
      start(1, 0, 2'b00, 32'h300, 0);
      if (st !== 9'b1_0_0_1_0_1111) begin n_fail++; $display("FAIL rst_mid_access: got %b expected 100101111", st); end
      n_chk++;
      #2 reset = 1;
      #1;
      if ({st, read_data, bus_address} !== {S_IDLE, 62'h0}) begin
         n_fail++; $display("FAIL rst_mid_async: got %b %h %h expected %b 0 0", st, read_data, bus_address, S_IDLE);
      end
      n_chk++;
      #1 reset = 0;
      tick();
      bus_ack = 1;
      start(0, 1, 2'b00, 32'h10, 32'h55);
      if ({st, bus_data_out} !== {9'b1_0_0_0_1_1111, 32'h55}) begin
         n_fail++; $display("FAIL rst_after_access: got %b %h expected 100011111 55", st, bus_data_out);
      end
      n_chk++;
      tick();
      bus_ack = 0;
      if (st !== S_DONE) begin n_fail++; $display("FAIL rst_after_done: got %b expected %b", st, S_DONE); end
      n_chk++;
      tick();
   endtask

   initial begin
      test_reset();
      test_long_read();
      test_byte_write();
      test_word_read();
      test_misaligned();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
